// File: rtl/icetap_dump_if.sv
// Scan-side bundle between icetap_dump, the capture RAM read port and the
// host byte transmitter.
interface icetap_dump_if #(
  parameter int NR_SIGNALS = 16
);
  logic                  read_req_first;
  logic                  read_req_next;
  logic [NR_SIGNALS-1:0] read_data;
  logic [7:0]            out_data;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output read_req_first, read_req_next, out_data, out_valid,
    input  read_data, out_ready
  );

  modport slave (
    input  read_req_first, read_req_next, out_data, out_valid,
    output read_data, out_ready
  );
endinterface

// File: rtl/icetap_dump.sv
// Readout sequencer: walks the capture RAM from start_addr to stop_addr and
// streams a framed byte dump (5-byte header, then samples LSB byte first).
module icetap_dump #(
  parameter int NR_SIGNALS   = 16,
  parameter int RECORD_DEPTH = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                            scan_clk,
  input  logic                            scan_reset,
  input  logic [1:0]                      capture_state,
  input  logic [$clog2(RECORD_DEPTH)-1:0] start_addr,
  input  logic [$clog2(RECORD_DEPTH)-1:0] trigger_addr,
  input  logic [$clog2(RECORD_DEPTH)-1:0] stop_addr,
  input  logic                            dump_start,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  icetap_dump_if.master                   bus
);
  localparam int AW = $clog2(RECORD_DEPTH);
  localparam int B  = (NR_SIGNALS + 7) / 8;
  localparam int SW = B * 8;
  localparam int IW = $clog2(B > 5 ? B : 5) + 1;
  localparam int LW = $clog2(READ_LATENCY + 1) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_SEEK, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     n_q, n_d, t_q, t_d, rem_q, rem_d;
  logic [AW-1:0]   start_q, start_d, seek_q, seek_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   smp_q, smp_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d, first_q, first_d, next_q, next_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic [AW-1:0]   span, toff;
  logic [SW-1:0]   ext, shifted;
  logic            xfer;

  assign span    = stop_addr - start_addr;
  assign toff    = trigger_addr - start_addr;
  assign ext     = SW'(bus.read_data);
  assign shifted = smp_q >> 8;
  assign xfer    = valid_q && bus.out_ready;

  always_ff @(posedge scan_clk or posedge scan_reset) begin
    if (scan_reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      t_q     <= '0;
      rem_q   <= '0;
      start_q <= '0;
      seek_q  <= '0;
      lat_q   <= '0;
      idx_q   <= '0;
      smp_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      next_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      t_q     <= t_d;
      rem_q   <= rem_d;
      start_q <= start_d;
      seek_q  <= seek_d;
      lat_q   <= lat_d;
      idx_q   <= idx_d;
      smp_q   <= smp_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      next_q  <= next_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    t_d     = t_q;
    rem_d   = rem_q;
    start_d = start_q;
    seek_d  = seek_q;
    lat_d   = lat_q;
    idx_d   = idx_q;
    smp_d   = smp_q;
    data_d  = data_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    first_d = 1'b0;
    next_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dump_start && capture_state == 2'd0) begin
          state_d = S_HDR;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          data_d  = 8'hA5;
          idx_d   = '0;
          n_d     = 16'(span) + 16'd1;
          rem_d   = 16'(span) + 16'd1;
          t_d     = 16'(toff);
          start_d = start_addr;
        end
      end
      S_HDR: begin
        if (xfer) begin
          if (idx_q == IW'(4)) begin
            valid_d = 1'b0;
            first_d = 1'b1;
            seek_d  = start_q;
            state_d = S_SEEK;
          end else begin
            idx_d = idx_q + 1'b1;
            case (idx_q)
              IW'(0):  data_d = n_q[7:0];
              IW'(1):  data_d = n_q[15:8];
              IW'(2):  data_d = t_q[7:0];
              default: data_d = t_q[15:8];
            endcase
          end
        end
      end
      // WAIT is entered one cycle after the last SEEK request but on the
      // request cycle itself from SEND, hence the different counter seeds.
      S_SEEK: begin
        if (seek_q != '0) begin
          next_d = 1'b1;
          seek_d = seek_q - 1'b1;
        end else begin
          lat_d   = LW'(1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == LW'(READ_LATENCY)) begin
          smp_d   = ext;
          data_d  = ext[7:0];
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = S_SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_SEND: begin
        if (xfer) begin
          if (idx_q == IW'(B - 1)) begin
            valid_d = 1'b0;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              next_d  = 1'b1;
              lat_d   = '0;
              state_d = S_WAIT;
            end
          end else begin
            idx_d  = idx_q + 1'b1;
            smp_d  = shifted;
            data_d = shifted[7:0];
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      first_d = 1'b0;
      next_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign bus.out_data       = data_q;
  assign bus.out_valid      = valid_q;
  assign bus.read_req_first = first_q;
  assign bus.read_req_next  = next_q;
  assign busy               = busy_q;
  assign done               = done_q;
endmodule

// File: tb/tb_icetap_dump.sv
// Randomized self-checking bench for icetap_dump: a capture RAM model feeds
// the read port and each received frame is compared with one built from the RAM.
module tb_icetap_dump;
  localparam int D  = 16;
  localparam int NS = 16;
  localparam int L  = 2;
  localparam int B  = (NS + 7) / 8;

  logic       scan_clk = 1'b0;
  logic       scan_reset;
  logic [1:0] capture_state;
  logic [3:0] start_addr, trigger_addr, stop_addr;
  logic       dump_start, abort, busy, done;

  icetap_dump_if #(.NR_SIGNALS(NS)) bus ();

  icetap_dump #(.NR_SIGNALS(NS), .RECORD_DEPTH(D), .READ_LATENCY(L)) dut (
    .scan_clk      (scan_clk),
    .scan_reset    (scan_reset),
    .capture_state (capture_state),
    .start_addr    (start_addr),
    .trigger_addr  (trigger_addr),
    .stop_addr     (stop_addr),
    .dump_start    (dump_start),
    .abort         (abort),
    .busy          (busy),
    .done          (done),
    .bus           (bus)
  );

  always #5 scan_clk = ~scan_clk;

  int n_asserts = 0;
  int n_fails   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Capture RAM: read counter updates on the request edge, data one stage later.
  logic [NS-1:0] ram [D];
  int unsigned   rd_addr;
  logic [NS-1:0] rd_pipe;
  assign bus.read_data = rd_pipe;

  initial begin
    rd_addr = 0;
    rd_pipe = '0;
    forever begin
      @(posedge scan_clk);
      rd_pipe <= ram[rd_addr];
      if (bus.read_req_first)     rd_addr <= 0;
      else if (bus.read_req_next) rd_addr <= (rd_addr + 1) % D;
    end
  end

  int ready_pct = 100;
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge scan_clk);
      #1 bus.out_ready = ($urandom_range(99) < ready_pct);
    end
  end

  // Monitor
  logic [7:0] got [$];
  int   n_first, n_next, n_done, first_at, proto_err;
  logic prev_stall = 1'b0, prev_xfer = 1'b0, prev_done = 1'b0;
  logic [7:0] prev_data = '0;

  initial begin
    forever begin
      @(negedge scan_clk);
      if (prev_stall && !scan_reset && !(bus.out_valid && bus.out_data == prev_data)) proto_err++;
      if (bus.read_req_first && bus.read_req_next) proto_err++;
      if ((bus.read_req_first || bus.read_req_next) && got.size() < 5) proto_err++;
      if (bus.read_req_first) begin
        if (n_first == 0) first_at = got.size();
        n_first++;
      end
      if (bus.read_req_next) n_next++;
      if (done) begin
        n_done++;
        if (!prev_xfer) proto_err++;
      end
      if (prev_done && busy) proto_err++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      prev_stall = bus.out_valid && !bus.out_ready && !abort && !scan_reset;
      prev_data  = bus.out_data;
      prev_xfer  = bus.out_valid && bus.out_ready;
      prev_done  = done;
    end
  end

  task automatic clear_mon();
    got.delete();
    n_first = 0; n_next = 0; n_done = 0; first_at = -1; proto_err = 0;
  endtask

  task automatic fill_ram(input bit ramp);
    for (int i = 0; i < D; i++) ram[i] = ramp ? NS'(16'h1100 + i) : NS'($urandom);
  endtask

  task automatic kick(input int s, input int e, input int t);
    @(posedge scan_clk);
    #1;
    start_addr = 4'(s); stop_addr = 4'(e); trigger_addr = 4'(t);
    capture_state = 2'd0;
    clear_mon();
    dump_start = 1'b1;
    @(posedge scan_clk);
    #1 dump_start = 1'b0;
  endtask

  task automatic run_dump(input string name, input int s, input int e, input int t, input int pct);
    logic [7:0]  exp [$];
    logic [15:0] w;
    int n, tt, cyc;
    ready_pct = pct;
    kick(s, e, t);
    check({name, "_busy_rise"}, busy, 1);
    check({name, "_hdr0_valid"}, bus.out_valid, 1);
    check({name, "_hdr0_data"}, bus.out_data, 8'hA5);
    // Inputs change mid-dump; the dump must use the values latched at start.
    start_addr = 4'($urandom); stop_addr = 4'($urandom); trigger_addr = 4'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(posedge scan_clk);
      #1 dump_start = 1'b1;
    end
    @(posedge scan_clk);
    #1 dump_start = 1'b0;
    cyc = 0;
    while (n_done == 0 && cyc < 3000) begin
      @(posedge scan_clk);
      cyc++;
    end
    check({name, "_done_seen"}, n_done > 0, 1);
    repeat (3) @(posedge scan_clk);
    #1;
    n  = ((e - s + D) % D) + 1;
    tt = (t - s + D) % D;
    exp.push_back(8'hA5);
    exp.push_back(8'(n)); exp.push_back(8'(n >> 8));
    exp.push_back(8'(tt)); exp.push_back(8'(tt >> 8));
    for (int k = 0; k < n; k++) begin
      w = 16'(ram[(s + k) % D]);
      for (int b = 0; b < B; b++) exp.push_back(8'(w >> (8 * b)));
    end
    check({name, "_len"}, got.size(), exp.size());
    for (int i = 0; i < got.size() && i < exp.size(); i++)
      check($sformatf("%s_byte%0d", name, i), got[i], exp[i]);
    check({name, "_n_first"}, n_first, 1);
    check({name, "_n_next"}, n_next, s + n - 1);
    check({name, "_first_after_hdr"}, first_at, 5);
    check({name, "_n_done"}, n_done, 1);
    check({name, "_proto"}, proto_err, 0);
    check({name, "_busy_end"}, busy, 0);
  endtask

  task automatic wait_bytes(input string name, input int nb);
    int cyc = 0;
    while (got.size() < nb && cyc < 2000) begin
      @(posedge scan_clk);
      cyc++;
    end
    check({name, "_reached"}, got.size() >= nb, 1);
  endtask

  initial begin
    int nn;
    scan_reset = 1'b1;
    capture_state = 2'd0;
    start_addr = '0; stop_addr = '0; trigger_addr = '0;
    dump_start = 1'b0; abort = 1'b0;
    clear_mon();
    fill_ram(1'b1);
    #12;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data",  bus.out_data, 0);
    check("rst_first", bus.read_req_first, 0);
    check("rst_next",  bus.read_req_next, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    @(posedge scan_clk);
    #3 scan_reset = 1'b0;

    run_dump("basic", 0, 7, 3, 100);
    run_dump("wrap", 12, 3, 14, 100);
    run_dump("full", 5, 4, 9, 100);
    run_dump("bp", 0, 7, 3, 30);

    // Gating: capture not idle
    clear_mon();
    @(posedge scan_clk);
    #1 capture_state = 2'd1; dump_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge scan_clk);
      #1 check("gate_busy", busy, 0);
    end
    dump_start = 1'b0;
    @(posedge scan_clk);
    #1 capture_state = 2'd0;
    check("gate_bytes", got.size(), 0);
    check("gate_reqs", n_first + n_next, 0);

    for (int r = 0; r < 6; r++) begin
      fill_ram(1'b0);
      run_dump($sformatf("rnd%0d", r), int'($urandom_range(D - 1)), int'($urandom_range(D - 1)),
               int'($urandom_range(D - 1)), int'($urandom_range(100, 30)));
    end

    // Abort during the third sample
    fill_ram(1'b0);
    ready_pct = 100;
    kick(2, 9, 4);
    wait_bytes("abort", 5 + 2 * B + 1);
    #1 abort = 1'b1;
    @(posedge scan_clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", bus.out_valid, 0);
    nn = n_next;
    repeat (10) @(posedge scan_clk);
    #1;
    check("abort_no_done", n_done, 0);
    check("abort_no_reqs", n_next, nn);
    check("abort_idle_valid", bus.out_valid, 0);
    fill_ram(1'b0);
    run_dump("post_abort", 6, 1, 0, 60);

    // Asynchronous reset during SEND
    kick(3, 10, 5);
    wait_bytes("reset", 6);
    #3 scan_reset = 1'b1;
    #1;
    check("mreset_valid", bus.out_valid, 0);
    check("mreset_data",  bus.out_data, 0);
    check("mreset_first", bus.read_req_first, 0);
    check("mreset_next",  bus.read_req_next, 0);
    check("mreset_busy",  busy, 0);
    check("mreset_done",  done, 0);
    repeat (2) @(posedge scan_clk);
    #3 scan_reset = 1'b0;
    fill_ram(1'b0);
    run_dump("post_reset", 0, 15, 8, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/icetap_dump.md
# icetap_dump

Readout sequencer on the scan side of the icetap capture path. After a capture completes it walks the capture RAM in chronological order, from `start_addr` to `stop_addr` with wrap-around. It drives the capture block's `read_req_first`/`read_req_next` read port and emits a framed byte stream, header then samples, over a valid/ready interface to the host transmitter (UART/JTAG shifter). It runs entirely in the `scan_clk` domain. The capture-side addresses and state are quasi-static while the capture block is idle.

## Interface
- `NR_SIGNALS`, 16: width of one captured sample (`read_data`).
- `RECORD_DEPTH`, 256: capture RAM depth; power of two, 2..32768.
- `READ_LATENCY`, 2: cycles from a read request cycle to valid `read_data`.
- `scan_clk` in 1: the only clock.
- `scan_reset` in 1: reset; asynchronous, active-high.
- `capture_state` in 2: capture FSM state; 0 = IDLE.
- `start_addr`, `trigger_addr`, `stop_addr` in `$clog2(RECORD_DEPTH)` each: capture bookkeeping addresses.
- `dump_start` in 1: request a dump (level sampled each cycle).
- `abort` in 1: synchronous abort of a dump in progress.
- `read_req_first` out 1: resets the capture read address to 0.
- `read_req_next` out 1: increments the capture read address, mod `RECORD_DEPTH`.
- `read_data` in `NR_SIGNALS`: RAM word at the current read address.
- `out_data` out 8: stream byte.
- `out_valid` out 1: `out_data` valid.
- `out_ready` in 1: sink accepts the byte.
- `busy` out 1: dump in progress.
- `done` out 1: one-cycle pulse when a dump completes normally.

## Operation
- Bytes per sample: B = ceil(NR_SIGNALS/8). Each sample is sent LSB byte first; unused MSBs of the last byte are 0.
- A byte transfers on a cycle with `out_valid && out_ready`.
- Sample count N = ((stop_addr − start_addr) mod RECORD_DEPTH) + 1, range 1..RECORD_DEPTH, held in a 16-bit register.
- Trigger offset T = (trigger_addr − start_addr) mod RECORD_DEPTH.
- Frame, 5 header bytes then N·B sample bytes: 0xA5, N[7:0], N[15:8], T[7:0], T[15:8], then the samples.
- FSM states and transitions:
  - IDLE: on `dump_start && capture_state==0`, latch the three addresses, compute N and T, set `busy`, go to HDR. A `dump_start` while `capture_state!=0` is ignored.
  - HDR: present the 5 header bytes in order, then go to SEEK.
  - SEEK: assert `read_req_first` for 1 cycle. Then assert `read_req_next` for exactly `start_addr` consecutive cycles; with `start_addr`=0 there are none. Then go to WAIT.
  - WAIT: count `READ_LATENCY` cycles after the last request cycle, latch `read_data` into a sample register, go to SEND.
  - SEND: present B bytes from the sample register. After the last byte transfers, decrement the remaining count.
    - Remaining 0: go to DONE.
    - Otherwise: assert `read_req_next` for 1 cycle and go to WAIT.
  - DONE: pulse `done` for 1 cycle, clear `busy`, go to IDLE.
- Wrap-around at RAM end is handled by the capture read counter; this block never recomputes addresses after SEEK.
- `abort`, in any non-IDLE state: next cycle IDLE, `busy`=0, `out_valid`=0, no `done` pulse, no further read requests.
- `dump_start` while `busy` is ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `read_req_first`=0, `read_req_next`=0, `busy`=0, `done`=0, FSM=IDLE.
- All outputs are registered.
- `busy` rises the cycle after the accepting `dump_start`. The first header byte is valid in that same cycle.
- Once `out_valid` is asserted, `out_data` holds stable until the transfer. Only `abort` or reset may drop it.
- With `out_ready` tied high, consecutive bytes within HDR or SEND go out on consecutive cycles.
- Per-sample overhead: 1 request cycle + `READ_LATENCY` cycles.
- At most one read is outstanding; `read_req_first` and `read_req_next` are never high together.
- `done` asserts the cycle after the final byte transfer. `busy` is 0 in the following cycle.
- Reset mid-dump takes effect immediately (asynchronous), regardless of handshake state.

## Test plan
- Basic dump, RECORD_DEPTH=16, NR_SIGNALS=16, RAM[i]=0x1100+i, start=0, stop=7, trigger=3, out_ready=1 → stream A5 08 00 03 00, then 00 11, 01 11, … 07 11; `done` pulses once; exactly 7 `read_req_next` pulses, all after HDR.
- Wrap: start=12, stop=3, trigger=14 → header A5 08 00 02 00; samples from addresses 12,13,14,15,0,1,2,3; 12 `read_req_next` pulses during SEEK.
- Full buffer: start=5, stop=4 → N=16 (header bytes 10 00); 16 samples from address 5 around to 4.
- Backpressure: random `out_ready` at 30% duty → byte sequence identical to basic dump; `out_data` never changes while `out_valid && !out_ready`.
- Gating: `dump_start` with `capture_state`=1 → no output, `busy` stays 0. `dump_start` re-asserted mid-dump → ignored, frame unchanged.
- Abort/reset: `abort` during the 3rd sample → next cycle `busy`=0, `out_valid`=0, no `done`. A new dump then produces a complete frame. `scan_reset` mid-SEND → all outputs 0 immediately.
